move_arbiter: RTL and testbench
===============================

// Module: move_arbiter
// PURPOSE
//  Input controller placed ahead of the adventure-game room FSM.
//  Debounces the four raw direction buttons and converts each debounced press into one pending move request.
//  Arbitrates simultaneous requests, then issues one single-cycle move pulse at a time, with a guaranteed low gap between pulses.
//  This gap lets the downstream room FSM edge-detect every move. Requests are discarded while the game is locked (dragon fight / game over).
// PARAMETERS
//  DEBOUNCE_CYCLES  4  consecutive cycles raw input must differ from stable value to flip it (>=1)
//  COOLDOWN         2  cycles of all-low move outputs after each pulse (>=1)
// PORTS
//  CLK      in   1  clock, all state on posedge
//  Reset    in   1  synchronous, active-high reset
//  N,E,S,W  in   1  raw direction buttons, may bounce
//  Lock     in   1  high = moves forbidden; pending requests dropped
//  moveN/E/S/W out 1  registered one-cycle move pulses, at most one high
//  valid    out  1  high exactly in cycles where a move pulse is high
//  dir      out  2  granted direction N=0 E=1 S=2 W=3; holds last grant
//  pending  out  4  {W,S,E,N} outstanding requests
//  busy     out  1  state != IDLE
// BEHAVIOUR
//  Reset (sync, dominates all): stable=0, debounce counters=0, pending=0, state=IDLE, cooldown count=0, dir=0, rr pointer=N; every output 0.
//  Debounce, per button:
//   - raw==stable: counter <= 0.
//   - Otherwise counter increments; when it reaches DEBOUNCE_CYCLES-1 with raw still differing, stable <= raw and counter <= 0.
//   - Net effect: a change is accepted on the DEBOUNCE_CYCLES-th consecutive differing cycle.
//  Request capture:
//   - A stable 0->1 edge sets pending[i] on the following edge; releases are ignored.
//   - Holding a button gives exactly one request.
//   - If a set and a grant-clear hit the same bit on the same edge, the set wins.
//   - Lock high: pending <= 0 every cycle, and edges seen while locked are discarded (not replayed after unlock).
//  FSM states: IDLE, FIRE, COOL.
//   - IDLE -> FIRE when pending!=0 && !Lock. On that edge the winner's pending bit is cleared, dir <= winner, and the winner's move output is set.
//   - FIRE: exactly one move output and valid are high for one cycle. FIRE -> COOL unconditionally; outputs clear and the counter loads COOLDOWN.
//   - COOL: outputs low; counter decrements; -> IDLE on the edge where it equals 1.
//   - Lock rising during FIRE/COOL does not abort; the pulse and the cooldown complete.
//  Latency: raw press to pulse visible = DEBOUNCE_CYCLES+2 cycles when idle. Pulse spacing >= COOLDOWN+2 cycles, start to start.
//  Arbitration: fixed priority N>E>S>W, evaluated only in IDLE.
// CONFIGURATION
//  MOVE_RR_EN defined:
//   - Round-robin arbitration replaces fixed priority.
//   - Search starts at rr pointer and wraps W->N; after each grant, pointer <= (granted+1) mod 4.
//   - Pointer is reset to N.
//  MOVE_RR_EN undefined: fixed N>E>S>W; no pointer register.
// TESTING
//  1 N toggles 1,0,1,0 each cycle (DEBOUNCE_CYCLES=4) -> no pulse, pending=0; N then held 4 cycles -> single moveN, dir=0, valid for 1 cycle.
//  2 N held 50 cycles -> exactly one moveN pulse; release and re-press -> second pulse.
//  3 E and W rise same cycle (fixed) -> moveE, then moveW 4 cycles later (COOLDOWN=2), dir 1 then 3, pending 1010->1000->0000.
//  4 MOVE_RR_EN: grant N, then N and S rise together -> moveS first (pointer=E), then moveN.
//  5 Lock=1, S pressed and debounced -> no pulse, pending stays 0; Lock->0 with S still held -> still no pulse.
//  6 Reset asserted in COOL with pending=1010 -> next cycle pending=0, busy=0, all moves 0, dir=0; no later pulse without a new press.

Source files
------------

// File: rtl/move_arbiter.sv
// Debounced direction-button arbiter feeding the room FSM: one gapped move pulse at a time.
// Define MOVE_RR_EN for round-robin arbitration; fixed N>E>S>W priority otherwise.
module move_arbiter #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int COOLDOWN        = 2
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic       N,
   input  logic       E,
   input  logic       S,
   input  logic       W,
   input  logic       Lock,
   output logic       moveN,
   output logic       moveE,
   output logic       moveS,
   output logic       moveW,
   output logic       valid,
   output logic [1:0] dir,
   output logic [3:0] pending,
   output logic       busy
);

   localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int CDW = $clog2(COOLDOWN + 1);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CDW-1:0] CD_LOAD = CDW'(COOLDOWN);
   localparam logic [CDW-1:0] CD_ONE  = CDW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FIRE = 2'd1,
      COOL = 2'd2
   } state_t;

   logic [3:0]          raw;
   logic [3:0]          stable_q, stable_d;
   logic [3:0]          prev_q, prev_d;
   logic [3:0][DBW-1:0] db_cnt_q, db_cnt_d;
   logic [3:0]          rise;

   logic [3:0]          pending_q, pending_d;
   logic [3:0]          move_q, move_d;
   logic                valid_q, valid_d;
   logic [1:0]          dir_q, dir_d;
   logic [CDW-1:0]      cd_q, cd_d;
   state_t              state_q, state_d;

   logic                any_req;
   logic [1:0]          grant_idx;
   logic [3:0]          grant_oh;
   logic [3:0]          clr;

`ifdef MOVE_RR_EN
   logic [1:0]          ptr_q, ptr_d;
`endif

   assign raw = {W, S, E, N};

   always_comb begin
      stable_d = stable_q;
      db_cnt_d = '0;
      for (int i = 0; i < 4; i++) begin
         if (raw[i] != stable_q[i]) begin
            if (db_cnt_q[i] == DB_LAST)
               stable_d[i] = raw[i];
            else
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
         end
      end
      prev_d = stable_q;
   end

   assign rise    = stable_q & ~prev_q;
   assign any_req = |pending_q;

`ifdef MOVE_RR_EN
   // Scan downward so the candidate closest to the pointer is assigned last.
   always_comb begin
      grant_idx = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         if (pending_q[ptr_q + 2'(k)])
            grant_idx = ptr_q + 2'(k);
      end
   end
`else
   always_comb begin
      grant_idx = 2'd0;
      priority case (1'b1)
         pending_q[0]: grant_idx = 2'd0;
         pending_q[1]: grant_idx = 2'd1;
         pending_q[2]: grant_idx = 2'd2;
         pending_q[3]: grant_idx = 2'd3;
         default:      grant_idx = 2'd0;
      endcase
   end
`endif

   assign grant_oh = any_req ? (4'b0001 << grant_idx) : 4'b0000;

   always_comb begin
      state_d = state_q;
      cd_d    = cd_q;
      move_d  = 4'b0000;
      valid_d = 1'b0;
      dir_d   = dir_q;
      clr     = 4'b0000;
`ifdef MOVE_RR_EN
      ptr_d   = ptr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (any_req && !Lock) begin
               state_d = FIRE;
               clr     = grant_oh;
               dir_d   = grant_idx;
               move_d  = grant_oh;
               valid_d = 1'b1;
`ifdef MOVE_RR_EN
               ptr_d   = grant_idx + 2'd1;
`endif
            end
         end
         FIRE: begin
            state_d = COOL;
            cd_d    = CD_LOAD;
         end
         COOL: begin
            if (cd_q == CD_ONE) begin
               state_d = IDLE;
               cd_d    = '0;
            end else begin
               cd_d    = cd_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cd_d    = '0;
         end
      endcase
   end

   // A new press outranks a grant clearing the same bit.
   always_comb begin
      if (Lock)
         pending_d = 4'b0000;
      else
         pending_d = (pending_q & ~clr) | rise;
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         stable_q  <= '0;
         prev_q    <= '0;
         db_cnt_q  <= '0;
         pending_q <= '0;
         move_q    <= '0;
         valid_q   <= 1'b0;
         dir_q     <= 2'd0;
         cd_q      <= '0;
         state_q   <= IDLE;
      end else begin
         stable_q  <= stable_d;
         prev_q    <= prev_d;
         db_cnt_q  <= db_cnt_d;
         pending_q <= pending_d;
         move_q    <= move_d;
         valid_q   <= valid_d;
         dir_q     <= dir_d;
         cd_q      <= cd_d;
         state_q   <= state_d;
      end
   end

`ifdef MOVE_RR_EN
   always_ff @(posedge CLK) begin
      if (Reset)
         ptr_q <= 2'd0;
      else
         ptr_q <= ptr_d;
   end
`endif

   assign moveN   = move_q[0];
   assign moveE   = move_q[1];
   assign moveS   = move_q[2];
   assign moveW   = move_q[3];
   assign valid   = valid_q;
   assign dir     = dir_q;
   assign pending = pending_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_move_arbiter.sv
// Directed bench for move_arbiter: debounce, latency, arbitration, lock, reset.
// Expected values are hand-derived for DEBOUNCE_CYCLES=4, COOLDOWN=2.
module tb_move_arbiter;

   logic       CLK;
   logic       Reset;
   logic       N, E, S, W, Lock;
   logic       moveN, moveE, moveS, moveW;
   logic       valid;
   logic [1:0] dir;
   logic [3:0] pending;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;
   int pulses   = 0;
   int viol     = 0;
   int cnt [4];

   move_arbiter #(
      .DEBOUNCE_CYCLES(4),
      .COOLDOWN(2)
   ) dut (
      .CLK(CLK),
      .Reset(Reset),
      .N(N),
      .E(E),
      .S(S),
      .W(W),
      .Lock(Lock),
      .moveN(moveN),
      .moveE(moveE),
      .moveS(moveS),
      .moveW(moveW),
      .valid(valid),
      .dir(dir),
      .pending(pending),
      .busy(busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] moves();
      return {moveW, moveS, moveE, moveN};
   endfunction

   task automatic clear_counts();
      pulses = 0;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
   endtask

   // Advance one clock and sample just after the edge.
   task automatic cyc();
      logic [3:0] exp_m;
      @(posedge CLK);
      #1;
      exp_m = 4'b0000;
      if (valid === 1'b1) begin
         pulses++;
         cnt[dir]++;
         exp_m = 4'b0001 << dir;
      end
      if (moves() !== exp_m) viol++;
   endtask

   logic [3:0] rr_first, rr_second;

   initial begin
`ifdef MOVE_RR_EN
      rr_first  = 4'b0100;
      rr_second = 4'b0001;
`else
      rr_first  = 4'b0001;
      rr_second = 4'b0100;
`endif
      Reset = 1'b1;
      {N, E, S, W, Lock} = 5'b0;
      clear_counts();
      repeat (3) cyc();
      check("rst_moves", {28'd0, moves()}, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_dir", {30'd0, dir}, 32'd0);
      check("rst_pend", {28'd0, pending}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      Reset = 1'b0;
      repeat (2) cyc();

      // 1: bouncing input is rejected, then a clean press fires once
      clear_counts();
      for (int i = 0; i < 8; i++) begin
         N = (i % 2 == 0);
         cyc();
      end
      N = 1'b0;
      repeat (6) cyc();
      check("bounce_pulses", pulses, 0);
      check("bounce_pend", {28'd0, pending}, 32'd0);

      clear_counts();
      N = 1'b1;
      repeat (4) cyc();
      check("t1_pend_early", {28'd0, pending}, 32'd0);
      cyc();
      check("t1_pend_set", {28'd0, pending}, 32'h1);
      check("t1_no_pulse_yet", {31'd0, valid}, 32'd0);
      cyc();
      check("t1_moves", {28'd0, moves()}, 32'h1);
      check("t1_valid", {31'd0, valid}, 32'd1);
      check("t1_dir", {30'd0, dir}, 32'd0);
      check("t1_pend_clr", {28'd0, pending}, 32'd0);
      check("t1_busy", {31'd0, busy}, 32'd1);
      cyc();
      check("t1_valid_1cyc", {31'd0, valid}, 32'd0);
      check("t1_busy_cool", {31'd0, busy}, 32'd1);

      // 2: long hold gives one pulse; re-press gives another
      repeat (50) cyc();
      check("t2_hold_one", cnt[0], 1);
      N = 1'b0;
      repeat (10) cyc();
      check("t2_release", cnt[0], 1);
      N = 1'b1;
      repeat (10) cyc();
      check("t2_repress", cnt[0], 2);
      N = 1'b0;
      repeat (10) cyc();

      // 3: E and W together
      clear_counts();
      E = 1'b1;
      W = 1'b1;
      repeat (5) cyc();
      check("t3_pend_both", {28'd0, pending}, 32'ha);
      cyc();
      check("t3_moveE", {28'd0, moves()}, 32'h2);
      check("t3_dirE", {30'd0, dir}, 32'd1);
      check("t3_pend_W", {28'd0, pending}, 32'h8);
      repeat (3) cyc();
      check("t3_gap", {28'd0, moves()}, 32'd0);
      check("t3_gap_dir", {30'd0, dir}, 32'd1);
      cyc();
      check("t3_moveW", {28'd0, moves()}, 32'h8);
      check("t3_dirW", {30'd0, dir}, 32'd3);
      check("t3_pend_none", {28'd0, pending}, 32'd0);
      E = 1'b0;
      W = 1'b0;
      repeat (10) cyc();
      check("t3_total", pulses, 2);

      // 4: grant N, then N and S together
      N = 1'b1;
      repeat (6) cyc();
      check("t4_moveN", {28'd0, moves()}, 32'h1);
      N = 1'b0;
      repeat (10) cyc();
      N = 1'b1;
      S = 1'b1;
      repeat (6) cyc();
      check("t4_first", {28'd0, moves()}, {28'd0, rr_first});
      repeat (4) cyc();
      check("t4_second", {28'd0, moves()}, {28'd0, rr_second});
      N = 1'b0;
      S = 1'b0;
      repeat (10) cyc();

      // 5: press while locked is dropped, not replayed
      clear_counts();
      Lock = 1'b1;
      S = 1'b1;
      repeat (12) cyc();
      check("t5_lock_pend", {28'd0, pending}, 32'd0);
      check("t5_lock_pulse", cnt[2], 0);
      Lock = 1'b0;
      repeat (12) cyc();
      check("t5_unlock_pulse", cnt[2], 0);
      check("t5_unlock_pend", {28'd0, pending}, 32'd0);
      check("t5_unlock_busy", {31'd0, busy}, 32'd0);
      S = 1'b0;
      repeat (10) cyc();

      // 6: reset during cooldown with requests queued
      S = 1'b1;
      cyc();
      cyc();
      E = 1'b1;
      W = 1'b1;
      repeat (4) cyc();
      check("t6_moveS", {28'd0, moves()}, 32'h4);
      check("t6_dirS", {30'd0, dir}, 32'd2);
      cyc();
      check("t6_cool_busy", {31'd0, busy}, 32'd1);
      check("t6_cool_pend", {28'd0, pending}, 32'ha);
      Reset = 1'b1;
      {N, E, S, W} = 4'b0;
      cyc();
      check("t6_rst_pend", {28'd0, pending}, 32'd0);
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      check("t6_rst_moves", {28'd0, moves()}, 32'd0);
      check("t6_rst_dir", {30'd0, dir}, 32'd0);
      Reset = 1'b0;
      clear_counts();
      repeat (20) cyc();
      check("t6_no_pulse", pulses, 0);

      check("onehot_valid_dir", viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
